// File: rtl/alu_result_collector_if.sv
// Writeback port from the ALU result collector into the lane VRF.
// The master (collector) drives the write, the slave (VRF) returns wb_rdy.
interface alu_result_collector_if #(
  parameter int ADDR_W = 9
) ();
  logic              wb_vld;
  logic              wb_rdy;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_data;
  logic [3:0]        wb_bwe;

  modport master (output wb_vld, output wb_addr, output wb_data, output wb_bwe, input wb_rdy);
  modport slave  (input wb_vld, input wb_addr, input wb_data, input wb_bwe, output wb_rdy);
endinterface

// File: rtl/alu_result_collector.sv
// Collects lane ALU results into a credit-protected FIFO and writes them back to the VRF.
// Optional macro ALU_RES_BYPASS_EN presents a result to the VRF in its arrival cycle when the FIFO is empty.
module alu_result_collector #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 9
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [15:0]           elem_cnt_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [1:0]            sew_i,
  input  logic                  reduction_i,
  input  logic                  issue_vld_i,
  output logic                  issue_rdy_o,
  input  logic                  alu_vld_i,
  input  logic [31:0]           alu_result_i,
  alu_result_collector_if.master wb,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic [3:0] sew_to_bwe(input logic [1:0] sew);
    case (sew)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [15:0]         elem_cnt_q, elem_cnt_d, issued_q, issued_d, received_q, received_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          sew_q, sew_d;
  logic                red_q, red_d, err_q, err_d, done_q, done_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d, count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [31:0]         data_mem [DEPTH];
  logic [ADDR_W-1:0]   addr_mem [DEPTH];

  logic                fifo_empty, fifo_full, push, pop, issue_fire;
  logic                alu_err, alu_acc, keep, is_last;
  logic [ADDR_W-1:0]   res_addr;
`ifdef ALU_RES_BYPASS_EN
  logic                byp;
`endif

  // Datapath control: credit, acceptance and FIFO push/pop
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CNT_W'(DEPTH));
    issue_rdy_o = (state_q == RUN) && (issued_q < elem_cnt_q) &&
                  ((SUM_W'(inflight_q) + SUM_W'(count_q)) < SUM_W'(DEPTH));
    issue_fire  = issue_vld_i & issue_rdy_o;
    pop         = !fifo_empty & wb.wb_rdy;
    alu_err     = alu_vld_i && ((inflight_q == '0) || (state_q == IDLE) || (fifo_full && !pop));
    alu_acc     = alu_vld_i & !alu_err;
    is_last     = (received_q == elem_cnt_q - 16'd1);
    keep        = alu_acc & (!red_q | is_last);
    res_addr    = red_q ? base_q : base_q + ADDR_W'(received_q);
`ifdef ALU_RES_BYPASS_EN
    // Kept free of wb_rdy so the bypass valid never depends on the VRF ready
    byp         = alu_vld_i && fifo_empty && (inflight_q != '0) && (state_q != IDLE) &&
                  (!red_q || is_last);
    push        = keep & !(byp & wb.wb_rdy);
`else
    push        = keep;
`endif
  end

  always_comb begin
    wb.wb_vld  = !fifo_empty;
    wb.wb_data = fifo_empty ? '0 : data_mem[rd_ptr_q];
    wb.wb_addr = fifo_empty ? '0 : addr_mem[rd_ptr_q];
    wb.wb_bwe  = fifo_empty ? '0 : sew_to_bwe(sew_q);
`ifdef ALU_RES_BYPASS_EN
    if (byp) begin
      wb.wb_vld  = 1'b1;
      wb.wb_data = alu_result_i;
      wb.wb_addr = res_addr;
      wb.wb_bwe  = sew_to_bwe(sew_q);
    end
`endif
  end

  // Sequencer and counters
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    base_d     = base_q;
    sew_d      = sew_q;
    red_d      = red_q;
    issued_d   = issued_q + {15'd0, issue_fire};
    received_d = received_q + {15'd0, alu_acc};
    inflight_d = inflight_q + CNT_W'(issue_fire) - CNT_W'(alu_acc);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    err_d      = err_q | alu_err;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (elem_cnt_i != 16'd0) begin
            elem_cnt_d = elem_cnt_i;
            base_d     = base_addr_i;
            sew_d      = sew_i;
            red_d      = reduction_i;
            issued_d   = '0;
            received_d = '0;
            inflight_d = '0;
            state_d    = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (received_d == elem_cnt_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      elem_cnt_q <= '0;
      base_q     <= '0;
      sew_q      <= '0;
      red_q      <= 1'b0;
      issued_q   <= '0;
      received_q <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      base_q     <= base_d;
      sew_q      <= sew_d;
      red_q      <= red_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= alu_result_i;
      addr_mem[wr_ptr_q] <= res_addr;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign overflow_err_o = err_q;

  credit_ok: assert property (@(posedge clk) disable iff (!rstn)
    (DEPTH >= LATENCY) && ((SUM_W'(inflight_q) + SUM_W'(count_q)) <= SUM_W'(DEPTH)));
endmodule
